// File: rtl/display_bcd_ctrl_pkg.sv
// Shared types and constants for the display BCD controller (package disp_pkg).
package disp_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Largest magnitude representable with the given number of decimal digits.
    function automatic longint max_val(input int digits);
        longint r;
        r = 1;
        for (int i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage

// File: rtl/display_bcd_ctrl_bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/display_bcd_ctrl.sv
// Signed value -> packed BCD for the 7-segment decoder, one double-dabble bit per cycle.
// Optional DISP_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module display_bcd_ctrl
    import disp_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int IN_W   = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [IN_W-1:0] valor_i,
    input  logic            valor_valid,
    output logic            valor_ready,
    output logic [31:0]     segmentos,
    output logic            neg,
    output logic            overflow,
    output logic            ocupado
);

    localparam int     BCD_W  = 4 * DIGITS;
    localparam int     NSHIFT = $clog2(10 ** DIGITS);
    localparam int     CNT_W  = $clog2(NSHIFT + 1);
    localparam longint MAXV   = max_val(DIGITS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IN_W-1:0]    mag_q, mag_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   disp_w;
    logic [BCD_W-1:0]   seg_q, seg_d;
    logic               sign_q, sign_d;
    logic               ovf_q, ovf_d;
    logic               neg_q, neg_d;
    logic               ovfo_q, ovfo_d;
    logic [IN_W-1:0]    abs_w;
    logic               big_w;

    // Two's-complement negate of the most negative value gives 2**(IN_W-1) as unsigned.
    assign abs_w = valor_i[IN_W-1] ? ((~valor_i) + IN_W'(1)) : valor_i;
    assign big_w = 64'(abs_w) > 64'(MAXV);

    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (bcd_q[4*k +: 4]),
            .digit_o (bcd_adj[4*k +: 4])
        );
    end

`ifdef DISP_ZERO_BLANK_EN
    logic lead;
    always_comb begin
        disp_w = bcd_q;
        lead   = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            if (lead && (bcd_q[4*k +: 4] == 4'd0)) begin
                disp_w[4*k +: 4] = BCD_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    assign disp_w = bcd_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        sign_d  = sign_q;
        ovf_d   = ovf_q;
        seg_d   = seg_q;
        neg_d   = neg_q;
        ovfo_d  = ovfo_q;
        case (state_q)
            IDLE: begin
                if (valor_valid) begin
                    sign_d  = valor_i[IN_W-1];
                    mag_d   = abs_w;
                    ovf_d   = big_w;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = big_w ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {bcd_adj[BCD_W-2:0], mag_q[NSHIFT-1]};
                mag_d = mag_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NSHIFT - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                neg_d   = sign_q;
                ovfo_d  = ovf_q;
                seg_d   = ovf_q ? {DIGITS{BCD_BLANK}} : disp_w;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seg_q   <= '0;
            neg_q   <= 1'b0;
            ovfo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            neg_q   <= neg_d;
            ovfo_q  <= ovfo_d;
        end
    end

    // Conversion working registers; a reset simply leaves them to be reloaded on accept.
    always_ff @(posedge clock) begin
        mag_q  <= mag_d;
        bcd_q  <= bcd_d;
        sign_q <= sign_d;
        ovf_q  <= ovf_d;
    end

    assign valor_ready = (state_q == IDLE);
    assign ocupado     = ~valor_ready;
    assign segmentos   = 32'(seg_q);
    assign neg         = neg_q;
    assign overflow    = ovfo_q;

endmodule
